// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, opcode/funct values,
// next-PC selects and datapath mux/ALU encodings.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CL_ADDU,
    CL_SUBU,
    CL_JR,
    CL_ORI,
    CL_LUI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_JAL,
    CL_ILLEGAL
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] NPC_SEL_PC_ADD_4 = 2'b00;
  localparam logic [1:0] NPC_SEL_REG_JMP  = 2'b01;
  localparam logic [1:0] NPC_SEL_J_JMP    = 2'b10;
  localparam logic [1:0] NPC_SEL_BEQ_JMP  = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_DM  = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  function automatic logic is_rtype_class(instr_class_t cls);
    return (cls == CL_ADDU) || (cls == CL_SUBU);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> IFU/datapath bundle: instruction and flag in, enables and selects out.
interface multicycle_ctrl_if;
  logic [31:0] instruction;
  logic        zero;
  logic        IRWr;
  logic        PCWr;
  logic [1:0]  NPCSel;
  logic        RegWr;
  logic [1:0]  RegDst;
  logic [1:0]  ExtOp;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic        MemWr;
  logic [1:0]  MemtoReg;
  logic [2:0]  state;
  logic        illegal;

  modport master (
    input  instruction, zero,
    output IRWr, PCWr, NPCSel, RegWr, RegDst, ExtOp, ALUSrc, ALUOp,
           MemWr, MemtoReg, state, illegal
  );

  modport slave (
    output instruction, zero,
    input  IRWr, PCWr, NPCSel, RegWr, RegDst, ExtOp, ALUSrc, ALUOp,
           MemWr, MemtoReg, state, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Purely combinational opcode/funct classifier; anything not recognised is CL_ILLEGAL.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    cls = CL_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = CL_ADDU;
          FN_SUBU: cls = CL_SUBU;
          FN_JR:   cls = CL_JR;
          default: cls = CL_ILLEGAL;
        endcase
      end
      OP_ORI:  cls = CL_ORI;
      OP_LUI:  cls = CL_LUI;
      OP_LW:   cls = CL_LW;
      OP_SW:   cls = CL_SW;
      OP_BEQ:  cls = CL_BEQ;
      OP_J:    cls = CL_J;
      OP_JAL:  cls = CL_JAL;
      default: cls = CL_ILLEGAL;
    endcase
  end

  assign illegal = (cls == CL_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: steps each IR through FETCH/DECODE/EXE/MEM/WB and
// writes the PC exactly once, in the instruction's final state.
//
//   state  | meaning
//   FETCH  | load IR from the IFU
//   DECODE | classify; jumps/jal/illegal retire here
//   EXE    | ALU operation; beq retires here
//   MEM    | data memory access; sw retires here
//   WB     | register write-back; ALU ops and lw retire here
//   HALT   | parked after an illegal opcode (trap mode) until reset
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic clk,
  input  logic reset,
  multicycle_ctrl_if.master bus
);

  state_t       state_q;
  state_t       state_d;
  instr_class_t cls;
  logic         dec_illegal;

  logic         irwr, pcwr, regwr, memwr, alusrc, ill, drive_alu;
  logic [1:0]   npc_sel, regdst, extop, aluop, memtoreg;
  logic [1:0]   alu_ext, alu_op;
  logic         alu_src;

  // Only opcode and funct steer control; the register/immediate fields belong to the datapath.
  logic         unused_instr_bits;
  assign unused_instr_bits = ^bus.instruction[25:6];

  multicycle_ctrl_decode u_decode (
    .op      (bus.instruction[31:26]),
    .funct   (bus.instruction[5:0]),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    alu_ext = EXT_ZERO;
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    case (cls)
      CL_SUBU: alu_op = ALU_SUB;
      CL_ORI: begin
        alu_src = 1'b1;
        alu_op  = ALU_OR;
      end
      CL_LUI: begin
        alu_ext = EXT_LUI;
        alu_src = 1'b1;
        alu_op  = ALU_OR;
      end
      CL_LW, CL_SW: begin
        alu_ext = EXT_SIGN;
        alu_src = 1'b1;
      end
      CL_BEQ:  alu_op = ALU_SUB;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = ST_FETCH;
    irwr      = 1'b0;
    pcwr      = 1'b0;
    npc_sel   = NPC_SEL_PC_ADD_4;
    regwr     = 1'b0;
    regdst    = REGDST_RT;
    memwr     = 1'b0;
    memtoreg  = M2R_ALU;
    ill       = 1'b0;
    drive_alu = 1'b0;
    extop     = EXT_ZERO;
    alusrc    = 1'b0;
    aluop     = ALU_ADD;

    case (state_q)
      ST_FETCH: begin
        irwr    = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (cls)
          CL_J: begin
            pcwr    = 1'b1;
            npc_sel = NPC_SEL_J_JMP;
          end
          CL_JR: begin
            pcwr    = 1'b1;
            npc_sel = NPC_SEL_REG_JMP;
          end
          CL_JAL: begin
            pcwr     = 1'b1;
            npc_sel  = NPC_SEL_J_JMP;
            regwr    = 1'b1;
            regdst   = REGDST_RA;
            memtoreg = M2R_PC4;
          end
          CL_ILLEGAL: begin
            ill = dec_illegal;
            if (ILLEGAL_TRAP) state_d = ST_HALT;
            else              pcwr    = 1'b1;
          end
          default: state_d = ST_EXE;
        endcase
      end
      ST_EXE: begin
        drive_alu = 1'b1;
        if (cls == CL_BEQ) begin
          pcwr    = 1'b1;
          npc_sel = bus.zero ? NPC_SEL_BEQ_JMP : NPC_SEL_PC_ADD_4;
        end else if (cls == CL_LW || cls == CL_SW) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // Keep the address path steady across the memory access.
        drive_alu = 1'b1;
        if (cls == CL_SW) begin
          memwr = 1'b1;
          pcwr  = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        drive_alu = 1'b1;
        regwr     = 1'b1;
        pcwr      = 1'b1;
        regdst    = is_rtype_class(cls) ? REGDST_RD : REGDST_RT;
        memtoreg  = (cls == CL_LW) ? M2R_DM : M2R_ALU;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    if (drive_alu) begin
      extop  = alu_ext;
      alusrc = alu_src;
      aluop  = alu_op;
    end
  end

  // Reset suppresses every side effect of the cycle it is asserted in.
  assign bus.IRWr     = irwr  & ~reset;
  assign bus.PCWr     = pcwr  & ~reset;
  assign bus.RegWr    = regwr & ~reset;
  assign bus.MemWr    = memwr & ~reset;
  assign bus.illegal  = ill   & ~reset;
  assign bus.NPCSel   = reset ? 2'b00 : npc_sel;
  assign bus.RegDst   = reset ? 2'b00 : regdst;
  assign bus.ExtOp    = reset ? 2'b00 : extop;
  assign bus.ALUSrc   = alusrc & ~reset;
  assign bus.ALUOp    = reset ? 2'b00 : aluop;
  assign bus.MemtoReg = reset ? 2'b00 : memtoreg;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a small IFU model (IR + PC) around two controller instances.
module tb_multicycle_ctrl;

  localparam logic [31:0] CODE_SEG_PC = 32'h0000_3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset_t;
  logic [31:0] imem_word, imem_t, ir, ir_t, pc, gpr_rs;
  logic        zero_in;

  multicycle_ctrl_if bus ();
  multicycle_ctrl_if bus_t ();

  multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut   (.clk(clk), .reset(reset),   .bus(bus));
  multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut_t (.clk(clk), .reset(reset_t), .bus(bus_t));

  assign bus.instruction   = ir;
  assign bus.zero          = zero_in;
  assign bus_t.instruction = ir_t;
  assign bus_t.zero        = 1'b0;

  // IFU model: IR loads on IRWr, PC moves on PCWr according to NPCSel.
  always @(posedge clk) begin
    if (bus.IRWr) ir <= imem_word;
    if (bus_t.IRWr) ir_t <= imem_t;
    if (bus.PCWr) begin
      case (bus.NPCSel)
        2'b00: pc <= pc + 32'd4;
        2'b01: pc <= gpr_rs;
        2'b10: pc <= CODE_SEG_PC + {4'h0, ir[25:0], 2'b00};
        2'b11: pc <= pc + 32'd4 + {{14{ir[15]}}, ir[15:0], 2'b00};
      endcase
    end
  end

  int total = 0;
  int bad = 0;

  // Per-cycle observations of one instruction.
  int          obs_n;
  logic [2:0]  obs_state [8];
  logic        obs_irwr [8], obs_pcwr [8], obs_regwr [8], obs_memwr [8], obs_ill [8];
  logic [1:0]  obs_npc [8], obs_regdst [8], obs_m2r [8];
  logic [31:0] pc_before, pc_after;

  // Reference expectations for one instruction.
  int          exp_n, exp_regwr_step, exp_memwr_step;
  int          exp_state [8];
  logic [1:0]  exp_npc, exp_regdst, exp_m2r;
  logic        exp_ill;
  logic [31:0] exp_pc;

  task automatic model_expect(input logic [31:0] ins, input logic z, input logic [31:0] pc0);
    string m;
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    m = "ill";
    if (op == 6'h00) begin
      if (fn == 6'h21) m = "addu";
      else if (fn == 6'h23) m = "subu";
      else if (fn == 6'h08) m = "jr";
    end
    else if (op == 6'h0d) m = "ori";
    else if (op == 6'h0f) m = "lui";
    else if (op == 6'h23) m = "lw";
    else if (op == 6'h2b) m = "sw";
    else if (op == 6'h04) m = "beq";
    else if (op == 6'h02) m = "j";
    else if (op == 6'h03) m = "jal";
    exp_regwr_step = -1;
    exp_memwr_step = -1;
    exp_npc = 2'b00;
    exp_regdst = 2'b00;
    exp_m2r = 2'b00;
    exp_ill = 1'b0;
    exp_pc = pc0 + 32'd4;
    for (int i = 0; i < 8; i++) exp_state[i] = 0;
    if (m == "addu" || m == "subu" || m == "ori" || m == "lui") begin
      exp_n = 4; exp_state[1] = 1; exp_state[2] = 2; exp_state[3] = 4;
      exp_regwr_step = 3;
      exp_regdst = (m == "addu" || m == "subu") ? 2'b01 : 2'b00;
    end else if (m == "lw") begin
      exp_n = 5; exp_state[1] = 1; exp_state[2] = 2; exp_state[3] = 3; exp_state[4] = 4;
      exp_regwr_step = 4; exp_m2r = 2'b01;
    end else if (m == "sw") begin
      exp_n = 4; exp_state[1] = 1; exp_state[2] = 2; exp_state[3] = 3;
      exp_memwr_step = 3;
    end else if (m == "beq") begin
      exp_n = 3; exp_state[1] = 1; exp_state[2] = 2;
      if (z) begin
        exp_npc = 2'b11;
        exp_pc = pc0 + 32'd4 + 32'($signed(ins[15:0])) * 4;
      end
    end else begin
      exp_n = 2; exp_state[1] = 1;
      if (m == "j" || m == "jal") begin
        exp_npc = 2'b10;
        exp_pc = CODE_SEG_PC + 32'(ins[25:0]) * 4;
      end
      if (m == "jr") begin
        exp_npc = 2'b01;
        exp_pc = gpr_rs;
      end
      if (m == "jal") begin
        exp_regwr_step = 1; exp_regdst = 2'b10; exp_m2r = 2'b10;
      end
      if (m == "ill") exp_ill = 1'b1;
    end
  endtask

  // Runs one instruction from FETCH until its PCWr cycle (at most 8 cycles).
  task automatic run_instr(input logic [31:0] ins, input logic z);
    logic done;
    imem_word = ins;
    zero_in = z;
    pc_before = pc;
    obs_n = 0;
    for (int k = 0; k < 8; k++) begin
      obs_state[k] = bus.state;   obs_irwr[k] = bus.IRWr;   obs_pcwr[k] = bus.PCWr;
      obs_regwr[k] = bus.RegWr;   obs_memwr[k] = bus.MemWr; obs_ill[k] = bus.illegal;
      obs_npc[k] = bus.NPCSel;    obs_regdst[k] = bus.RegDst; obs_m2r[k] = bus.MemtoReg;
      obs_n++;
      done = bus.PCWr;
      @(negedge clk);
      if (done === 1'b1) break;
    end
    pc_after = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    total++;
    if ({bus.IRWr, bus.PCWr, bus.RegWr, bus.MemWr} !== 4'b0000) begin
      bad++; $display("FAIL reset_enables: got %b expected 0000", {bus.IRWr, bus.PCWr, bus.RegWr, bus.MemWr});
    end
    total++;
    if ({bus.NPCSel, bus.RegDst, bus.ExtOp, bus.ALUOp, bus.MemtoReg} !== 10'd0) begin
      bad++; $display("FAIL reset_selects: got %h expected 0", {bus.NPCSel, bus.RegDst, bus.ExtOp, bus.ALUOp, bus.MemtoReg});
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.IRWr !== 1'b1) begin bad++; $display("FAIL release_irwr: got %b expected 1", bus.IRWr); end
  endtask

  task automatic test_addu();
    int seq [4] = '{0, 1, 2, 4};
    run_instr(32'h0022_1821, 1'b0);
    total++;
    if (obs_n !== 4) begin bad++; $display("FAIL addu_len: got %0d expected 4", obs_n); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs_state[k] !== 3'(seq[k])) begin bad++; $display("FAIL addu_state[%0d]: got %0d expected %0d", k, obs_state[k], seq[k]); end
    end
    total++;
    if ({obs_pcwr[3], obs_npc[3], obs_regwr[3], obs_regdst[3]} !== 6'b1_00_1_01) begin
      bad++; $display("FAIL addu_wb: got %b expected 100101", {obs_pcwr[3], obs_npc[3], obs_regwr[3], obs_regdst[3]});
    end
    total++;
    if (pc_after !== pc_before + 32'd4) begin bad++; $display("FAIL addu_pc: got %h expected %h", pc_after, pc_before + 32'd4); end
  endtask

  task automatic test_lw_sw();
    run_instr(32'h8c22_0004, 1'b0);
    total++;
    if (obs_n !== 5) begin bad++; $display("FAIL lw_len: got %0d expected 5", obs_n); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (obs_state[k] !== 3'(k)) begin bad++; $display("FAIL lw_state[%0d]: got %0d expected %0d", k, obs_state[k], k); end
    end
    total++;
    if ({obs_m2r[4], obs_regwr[4], obs_pcwr[4]} !== 4'b01_1_1) begin
      bad++; $display("FAIL lw_wb: got %b expected 0111", {obs_m2r[4], obs_regwr[4], obs_pcwr[4]});
    end
    run_instr(32'hac22_0004, 1'b0);
    total++;
    if (obs_n !== 4 || obs_state[3] !== 3'd3) begin bad++; $display("FAIL sw_len: got %0d/%0d expected 4/3", obs_n, obs_state[3]); end
    total++;
    if ({obs_memwr[3], obs_pcwr[3]} !== 2'b11) begin bad++; $display("FAIL sw_mem: got %b expected 11", {obs_memwr[3], obs_pcwr[3]}); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs_regwr[k] !== 1'b0) begin bad++; $display("FAIL sw_regwr[%0d]: got %b expected 0", k, obs_regwr[k]); end
    end
  endtask

  task automatic test_beq();
    run_instr(32'h1000_0003, 1'b1);
    total++;
    if (obs_n !== 3 || obs_npc[2] !== 2'b11) begin bad++; $display("FAIL beq_taken_npc: got %0d/%b expected 3/11", obs_n, obs_npc[2]); end
    total++;
    if (pc_after !== pc_before + 32'd16) begin bad++; $display("FAIL beq_taken_pc: got %h expected %h", pc_after, pc_before + 32'd16); end
    run_instr(32'h1000_0003, 1'b0);
    total++;
    if (obs_n !== 3 || obs_npc[2] !== 2'b00) begin bad++; $display("FAIL beq_not_npc: got %0d/%b expected 3/00", obs_n, obs_npc[2]); end
    total++;
    if (pc_after !== pc_before + 32'd4) begin bad++; $display("FAIL beq_not_pc: got %h expected %h", pc_after, pc_before + 32'd4); end
  endtask

  task automatic test_jumps();
    run_instr(32'h0c00_0042, 1'b0);
    total++;
    if (obs_n !== 2) begin bad++; $display("FAIL jal_len: got %0d expected 2", obs_n); end
    total++;
    if ({obs_regwr[1], obs_regdst[1], obs_m2r[1], obs_npc[1]} !== 7'b1_10_10_10) begin
      bad++; $display("FAIL jal_decode: got %b expected 1101010", {obs_regwr[1], obs_regdst[1], obs_m2r[1], obs_npc[1]});
    end
    total++;
    if (pc_after !== CODE_SEG_PC + 32'h108) begin bad++; $display("FAIL jal_pc: got %h expected %h", pc_after, CODE_SEG_PC + 32'h108); end
    gpr_rs = 32'h0000_3040;
    run_instr(32'h03e0_0008, 1'b0);
    total++;
    if (obs_n !== 2 || obs_npc[1] !== 2'b01) begin bad++; $display("FAIL jr_npc: got %0d/%b expected 2/01", obs_n, obs_npc[1]); end
    total++;
    if (pc_after !== 32'h0000_3040) begin bad++; $display("FAIL jr_pc: got %h expected 00003040", pc_after); end
  endtask

  task automatic test_illegal();
    run_instr(32'hfc00_0000, 1'b0);
    total++;
    if (obs_n !== 2 || obs_ill[1] !== 1'b1 || obs_pcwr[1] !== 1'b1) begin
      bad++; $display("FAIL illegal_decode: got n=%0d ill=%b pcwr=%b expected 2/1/1", obs_n, obs_ill[1], obs_pcwr[1]);
    end
    total++;
    if (obs_regwr[1] !== 1'b0 || obs_memwr[1] !== 1'b0) begin bad++; $display("FAIL illegal_enables: got %b%b expected 00", obs_regwr[1], obs_memwr[1]); end
    total++;
    if (pc_after !== pc_before + 32'd4) begin bad++; $display("FAIL illegal_pc: got %h expected %h", pc_after, pc_before + 32'd4); end
  endtask

  task automatic test_trap();
    int stray;
    imem_t = 32'hfc00_0000;
    reset_t = 1'b0;
    @(negedge clk);
    total++;
    if (bus_t.state !== 3'd1 || bus_t.illegal !== 1'b1 || bus_t.PCWr !== 1'b0) begin
      bad++; $display("FAIL trap_decode: got st=%0d ill=%b pcwr=%b expected 1/1/0", bus_t.state, bus_t.illegal, bus_t.PCWr);
    end
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_t.state !== 3'd7 || bus_t.PCWr !== 1'b0 || bus_t.IRWr !== 1'b0 || bus_t.RegWr !== 1'b0 || bus_t.MemWr !== 1'b0) stray++;
    end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL trap_halt: got %0d bad cycles expected 0", stray); end
    reset_t = 1'b1;
    @(negedge clk);
    total++;
    if (bus_t.state !== 3'd0) begin bad++; $display("FAIL trap_reset: got %0d expected 0", bus_t.state); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pc0;
    pc0 = pc;
    imem_word = 32'hac22_0004;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (bus.state !== 3'd3 || bus.MemWr !== 1'b0 || bus.PCWr !== 1'b0) begin
      bad++; $display("FAIL midreset_mem: got st=%0d memwr=%b pcwr=%b expected 3/0/0", bus.state, bus.MemWr, bus.PCWr);
    end
    @(negedge clk);
    total++;
    if (bus.state !== 3'd0) begin bad++; $display("FAIL midreset_state: got %0d expected 0", bus.state); end
    total++;
    if (pc !== pc0) begin bad++; $display("FAIL midreset_pc: got %h expected %h", pc, pc0); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [5:0]  ops [12] = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f, 6'h08};
    logic [5:0]  fns [4]  = '{6'h21, 6'h23, 6'h08, 6'h20};
    logic        z;
    for (int t = 0; t < 60; t++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 11)];
      if (ins[31:26] == 6'h00) begin
        ins[5:0] = fns[$urandom_range(0, 3)];
        ins[10:6] = 5'd0;
      end
      z = 1'($urandom_range(0, 1));
      gpr_rs = CODE_SEG_PC + {$urandom_range(0, 255), 2'b00};
      model_expect(ins, z, pc);
      run_instr(ins, z);
      total++;
      if (obs_n !== exp_n) begin bad++; $display("FAIL rand_len %h: got %0d expected %0d", ins, obs_n, exp_n); end
      for (int k = 0; k < exp_n && k < obs_n; k++) begin
        total++;
        if ({obs_state[k], obs_irwr[k], obs_pcwr[k], obs_regwr[k], obs_memwr[k], obs_ill[k]} !==
            {3'(exp_state[k]), k == 0, k == exp_n - 1, k == exp_regwr_step, k == exp_memwr_step, exp_ill && k == 1}) begin
          bad++;
          $display("FAIL rand_step %h[%0d]: got st=%0d ir=%b pc=%b rw=%b mw=%b il=%b expected st=%0d ir=%b pc=%b rw=%b mw=%b il=%b",
                   ins, k, obs_state[k], obs_irwr[k], obs_pcwr[k], obs_regwr[k], obs_memwr[k], obs_ill[k],
                   exp_state[k], k == 0, k == exp_n - 1, k == exp_regwr_step, k == exp_memwr_step, exp_ill && k == 1);
        end
      end
      total++;
      if (obs_npc[obs_n - 1] !== exp_npc) begin bad++; $display("FAIL rand_npc %h: got %b expected %b", ins, obs_npc[obs_n - 1], exp_npc); end
      if (exp_regwr_step >= 0) begin
        total++;
        if ({obs_regdst[exp_regwr_step], obs_m2r[exp_regwr_step]} !== {exp_regdst, exp_m2r}) begin
          bad++; $display("FAIL rand_wb %h: got %b expected %b", ins, {obs_regdst[exp_regwr_step], obs_m2r[exp_regwr_step]}, {exp_regdst, exp_m2r});
        end
      end
      total++;
      if (pc_after !== exp_pc) begin bad++; $display("FAIL rand_pc %h: got %h expected %h", ins, pc_after, exp_pc); end
    end
  endtask

  initial begin
    reset = 1'b1;
    reset_t = 1'b1;
    imem_word = 32'd0;
    imem_t = 32'd0;
    ir = 32'd0;
    ir_t = 32'd0;
    zero_in = 1'b0;
    gpr_rs = 32'd0;
    pc = CODE_SEG_PC;
    test_reset();
    test_addu();
    test_lw_sw();
    test_beq();
    test_jumps();
    test_illegal();
    test_trap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
